// File: rtl/ssriscv_lsu.sv
// Load/store unit: one outstanding data-memory access per request, response as a one-cycle pulse.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned halfword/word accesses into byte accesses.
//   state  | meaning
//   IDLE   | ready for a request
//   ACCESS | single aligned memory cycle
//   SPLIT  | one byte per cycle for a misaligned access
//   RESP   | response pulse
module ssriscv_lsu #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [2:0]  func,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_nx, asm_q, asm_nx;
  logic [2:0]  func_q;
  logic        we_q, err_q, err_nx;
  logic [1:0]  cnt_q, cnt_nx, last_q, size_m1;
  logic [4:0]  lane;
  logic        func_ok, range_err, misalign;
  logic [32:0] end_addr;

  function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (f == 3'b001)      r = {{16{d[15]}}, d[15:0]};
    else if (f == 3'b101) r = {16'b0, d[15:0]};
    return r;
  endfunction

  always_comb begin
    size_m1 = 2'd0;
    case (req_func[1:0])
      2'b01:   size_m1 = 2'd1;
      2'b10:   size_m1 = 2'd3;
      default: size_m1 = 2'd0;
    endcase
    case (req_func)
      3'b000, 3'b001, 3'b010: func_ok = 1'b1;
      3'b100, 3'b101:         func_ok = !req_we;
      default:                func_ok = 1'b0;
    endcase
    // 33-bit sum so an access straddling 2**32 is not hidden by wrap-around
    end_addr  = {1'b0, req_addr} + {31'b0, size_m1};
    range_err = |end_addr[32:ADDR_W];
    misalign  = ((size_m1 == 2'd1) && req_addr[0]) ||
                ((size_m1 == 2'd3) && (req_addr[1:0] != 2'b00));
  end

  assign lane = {cnt_q, 3'b000};

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt_q;
    asm_nx         = asm_q;
    rdata_nx       = rdata_q;
    err_nx         = err_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = 32'b0;
    resp_err       = 1'b0;
    mem_addr       = 32'b0;
    mem_write_data = 32'b0;
    func           = 3'b000;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rdata_nx = 32'b0;
          asm_nx   = 32'b0;
          cnt_nx   = 2'd0;
          if (!func_ok || range_err) begin
            err_nx   = 1'b1;
            state_nx = RESP;
          end else if (misalign) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            err_nx   = 1'b0;
            state_nx = SPLIT;
`else
            err_nx   = 1'b1;
            state_nx = RESP;
`endif
          end else begin
            err_nx   = 1'b0;
            state_nx = ACCESS;
          end
        end
      end
      ACCESS: begin
        mem_addr       = addr_q;
        func           = func_q;
        mem_write_data = wdata_q;
        mem_write      = we_q;
        mem_read       = !we_q;
        if (!we_q) rdata_nx = mem_read_data;
        state_nx = RESP;
      end
      SPLIT: begin
        mem_addr       = addr_q + {30'b0, cnt_q};
        func           = we_q ? 3'b000 : 3'b100;
        mem_write_data = {24'b0, wdata_q[lane +: 8]};
        mem_write      = we_q;
        mem_read       = !we_q;
        if (!we_q) asm_nx[lane +: 8] = mem_read_data[7:0];
        if (cnt_q == last_q) begin
          if (!we_q) rdata_nx = extend(func_q, asm_nx);
          state_nx = RESP;
        end else begin
          cnt_nx = cnt_q + 2'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      func_q  <= 3'b000;
      we_q    <= 1'b0;
      last_q  <= 2'd0;
      cnt_q   <= 2'd0;
      asm_q   <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt_q   <= cnt_nx;
      asm_q   <= asm_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        func_q  <= req_func;
        we_q    <= req_we;
        last_q  <= size_m1;
      end
    end
  end

endmodule

// File: tb/tb_ssriscv_lsu.sv
// Scoreboard bench for ssriscv_lsu with a negedge byte-array data memory.
module tb_ssriscv_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func = 3'b000;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [2:0]  func;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data = 32'b0;

  ssriscv_lsu #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .func(func),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          stb;
  } resp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f;
  } wr_t;

  resp_t exp_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    fails = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    acc_count = 0;
  int    strobe_cnt = 0;
  bit    mem_init_done = 1'b0;
  logic [7:0] mem [0:255];

  always @(posedge clk) cyc++;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_load(input logic [2:0] f, input logic [31:0] a);
    logic [7:0]  i;
    logic [31:0] r;
    i = a[7:0];
    case (f)
      3'b000:  r = {{24{mem[i][7]}}, mem[i]};
      3'b100:  r = {24'b0, mem[i]};
      3'b001:  r = {{16{mem[i+8'd1][7]}}, mem[i+8'd1], mem[i]};
      3'b101:  r = {16'b0, mem[i+8'd1], mem[i]};
      default: r = {mem[i+8'd3], mem[i+8'd2], mem[i+8'd1], mem[i]};
    endcase
    return r;
  endfunction

  // Data memory and monitor: memory acts on negedge, outputs sampled mid-cycle.
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] = i[7:0];
      mem_init_done = 1'b1;
    end
    if (mem_read || mem_write) strobe_cnt++;
    if (mem_read) mem_read_data = mem_load(func, mem_addr);
    if (mem_write) begin
      if (wr_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_write: got addr %h data %h", mem_addr, mem_write_data);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check32("wr_addr", mem_addr, w.addr);
        check32("wr_data", mem_write_data, w.data);
        check32("wr_func", {29'b0, func}, {29'b0, w.f});
      end
      mem[mem_addr[7:0]] = mem_write_data[7:0];
      if (func != 3'b000) mem[mem_addr[7:0] + 8'd1] = mem_write_data[15:8];
      if (func == 3'b010) begin
        mem[mem_addr[7:0] + 8'd2] = mem_write_data[23:16];
        mem[mem_addr[7:0] + 8'd3] = mem_write_data[31:24];
      end
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_resp: got rdata %h err %b", resp_rdata, resp_err);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check32("resp_rdata", resp_rdata, e.rdata);
        check32("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        check32("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
        check32("strobes", 32'(strobe_cnt), 32'(e.stb));
      end
    end
    if (rst_n && req_valid && req_ready) begin
      acc_cyc = cyc + 1;
      strobe_cnt = 0;
      acc_count++;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; fails++;
      $display("FAIL resp_timeout: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    int n;
    req_we = we; req_func = f; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] erd, input logic eerr,
                       input int lat, input int stb);
    exp_q.push_back('{erd, eerr, lat, stb});
    drive(we, f, a, d);
    drain();
  endtask

  initial begin
    int acc0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check32("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check32("rst_resp_rdata", resp_rdata, 32'd0);
    check32("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_mem_wdata", mem_write_data, 32'd0);
    check32("rst_func", {29'b0, func}, 32'd0);
    check32("rst_strobes", {30'b0, mem_write, mem_read}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    wr_q.push_back('{32'h10, 32'hDEADBEEF, 3'b010});
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, 1);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 1);
    issue(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2, 1);
    issue(1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1, 1, 0);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    issue(1'b0, 3'b010, 32'hFC, 32'h0, 32'hFFFEFDFC, 1'b0, 2, 1);
    issue(1'b0, 3'b010, 32'hFD, 32'h0, 32'h0, 1'b1, 1, 0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0);
    issue(1'b0, 3'b000, 32'hFF, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 1);
    issue(1'b0, 3'b001, 32'hFF, 32'h0, 32'h0, 1'b1, 1, 0);
    issue(1'b1, 3'b010, 32'hFFFFFFFC, 32'h1, 32'h0, 1'b1, 1, 0);

`ifdef LSU_MISALIGN_SPLIT_EN
    wr_q.push_back('{32'h21, 32'h44, 3'b000});
    wr_q.push_back('{32'h22, 32'h33, 3'b000});
    wr_q.push_back('{32'h23, 32'h22, 3'b000});
    wr_q.push_back('{32'h24, 32'h11, 3'b000});
    issue(1'b1, 3'b010, 32'h21, 32'h11223344, 32'h0, 1'b0, 5, 4);
    issue(1'b0, 3'b010, 32'h21, 32'h0, 32'h11223344, 1'b0, 5, 4);
    wr_q.push_back('{32'h24, 32'h81, 3'b000});
    issue(1'b1, 3'b000, 32'h24, 32'h81, 32'h0, 1'b0, 2, 1);
    issue(1'b0, 3'b001, 32'h23, 32'h0, 32'hFFFF8122, 1'b0, 3, 2);
    issue(1'b0, 3'b101, 32'h23, 32'h0, 32'h00008122, 1'b0, 3, 2);
    wr_q.push_back('{32'h31, 32'hB6, 3'b000});
    wr_q.push_back('{32'h32, 32'hA5, 3'b000});
    issue(1'b1, 3'b001, 32'h31, 32'hFFFFA5B6, 32'h0, 1'b0, 3, 2);
    issue(1'b0, 3'b001, 32'hFF, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    issue(1'b0, 3'b010, 32'h21, 32'h0, 32'h0, 1'b1, 1, 0);
    issue(1'b1, 3'b001, 32'h23, 32'h1234, 32'h0, 1'b1, 1, 0);
`endif

    // req_valid held across a whole transaction: second accept only after RESP
    exp_q.push_back('{32'hFFFFFFDE, 1'b0, 2, 1});
    exp_q.push_back('{32'hFFFFFFDE, 1'b0, 2, 1});
    req_we = 1'b0; req_func = 3'b000; req_addr = 32'h13; req_valid = 1'b1;
    acc0 = acc_count;
    @(posedge clk); #1;
    check32("held_ready_access", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check32("held_ready_resp", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check32("held_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
    check32("held_accepts", 32'(acc_count - acc0), 32'd2);

    // Reset in the middle of an access: no response, strobes drop immediately
`ifdef LSU_MISALIGN_SPLIT_EN
    drive(1'b0, 3'b010, 32'h21, 32'h0);
    @(posedge clk); #1;
`else
    drive(1'b0, 3'b010, 32'h10, 32'h0);
`endif
    check32("abort_pre_read", {31'b0, mem_read}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check32("abort_strobes", {30'b0, mem_write, mem_read}, 32'd0);
    check32("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check32("abort_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check32("writes_left", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ssriscv_lsu.md
Name: ssriscv_lsu

Overview:
Load/store unit: initiator side of the core's data-memory interface. Accepts one load/store request at a time from the MEM stage over a valid/ready handshake and drives mem_addr/func/mem_write/mem_read/mem_write_data toward the data memory. The data memory acts on negedge clk, and this block captures mem_read_data on the following posedge. Returns a one-cycle response pulse carrying load data or an error flag.

Parameters:
ADDR_W, 8, number of valid byte-address bits; any access touching a byte address >= 2**ADDR_W is an error.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  synchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request (1 only in IDLE).
req_we  in  1  1 = store, 0 = load.
req_func  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  qualified by resp_valid: illegal func, out of range, or misaligned (see feature).
mem_addr  out  32  to data memory.
mem_write_data  out  32  to data memory.
func  out  3  to data memory.
mem_write  out  1  to data memory.
mem_read  out  1  to data memory.
mem_read_data  in  32  from data memory; valid at the posedge after the cycle in which mem_read is high.

Behaviour:
- States: IDLE, ACCESS, SPLIT, RESP.
- Reset: state = IDLE, and req_ready = 1. All other outputs are 0: resp_valid, resp_rdata, resp_err, mem_addr, mem_write_data, func, mem_write, mem_read.
- Reset mid-operation aborts the access. No response is produced, and mem_read/mem_write are 0 from the next cycle.
- Accept occurs on the posedge where req_valid && req_ready. The request is registered, and req_ready drops to 0 until the block returns to IDLE.
- Size: 000/100 = 1 byte, 001/101 = 2 bytes, 010 = 4 bytes.
- Legal func: stores 000/001/010; loads 000/001/010/100/101.
- Error at accept (illegal func, or req_addr + size - 1 >= 2**ADDR_W, computed without 32-bit wrap):
  - Go to RESP with resp_err = 1 and resp_rdata = 0.
  - No memory strobe is asserted.
  - Response latency is 1 cycle after accept.
- Aligned access (addr[0] = 0 for halfword, addr[1:0] = 0 for word, bytes always):
  - ACCESS lasts exactly 1 cycle and drives mem_addr = req_addr, func = req_func, mem_write_data = req_wdata, and mem_write = req_we or mem_read = !req_we.
  - The posedge ending ACCESS captures mem_read_data into resp_rdata (loads) and moves to RESP.
  - RESP lasts 1 cycle with resp_valid = 1, then returns to IDLE with outputs zeroed.
  - resp_valid rises 2 cycles after the accept edge; throughput is 1 request per 3 cycles.
- Memory strobes are 0 in every state except ACCESS and SPLIT.
- resp_valid, resp_rdata and resp_err are 0 outside RESP.

Optional Feature:
LSU_MISALIGN_SPLIT_EN
- Defined: a misaligned halfword or word enters SPLIT. A byte counter runs k = 0..size-1, one cycle per byte, with mem_addr = req_addr + k.
  - Stores: func = 000 and mem_write_data = {24'b0, req_wdata[8k+7:8k]}.
  - Loads: func = 100; the posedge ending each cycle captures mem_read_data[7:0] into byte lane k of an assembly register.
  - After the last byte, go to RESP. The result is sign-extended from bit 15 (func 001) or taken as-is/zero-extended (010/101).
  - Latency is size+1 cycles after accept (halfword 3, word 5).
  - The range check in the error rule still applies before splitting.
- Undefined: misaligned halfword or word is an error: RESP with resp_err = 1, no memory strobe, latency 1.

Test Plan:
- Reset asserted 2 cycles → req_ready = 1 and every other output 0. Then store word: addr 0x10, wdata 0xDEADBEEF, func 010 → ACCESS drives mem_write = 1, func = 010, mem_addr = 0x10; resp_valid 2 cycles after accept with resp_err = 0 and resp_rdata = 0.
- Load after memory word 0x10 = 0xDEADBEEF:
  - LB at 0x13 (func 000) → resp_rdata = 0xFFFFFFDE.
  - LBU at 0x13 (func 100) → 0x000000DE.
  - LH at 0x12 (func 001) → 0xFFFFDEAD.
  - LHU at 0x10 (func 101) → 0x0000BEEF.
  - Each responds 2 cycles after accept.
- Illegal func → resp_valid 1 cycle after accept with resp_err = 1 and mem_read/mem_write never asserted: store func 100; load func 011; LW at 0xFC with ADDR_W = 8 (ends at 0xFF, legal) vs 0xFD (error).
- Misaligned, feature defined:
  - SW 0x11223344 at 0x21 → four byte writes to 0x21..0x24 with data 0x44, 0x33, 0x22, 0x11.
  - LW at 0x21 → 0x11223344 after 5 cycles.
  - LH at 0x23 of bytes 0x22 (at 0x23), 0x81 (at 0x24) → 0xFFFF8122.
- Misaligned, feature undefined: LW at 0x21 → resp_err = 1 at latency 1, no memory strobes.
- rst_n low during SPLIT cycle 2 → no resp_valid, strobes 0 the next cycle, req_ready = 1 after release. req_valid held through RESP → second request accepted only once back in IDLE.
